// File: rtl/ciq_issue_select_pkg.sv
// Shared layout for the centralized issue queue: widths, entry payload record and
// the operand-ready helper used by both the dispatch writer and the issue side.
package ciq_issue_select_pkg;

    localparam int OPCODE      = 7;
    localparam int PRF_WIDTH   = 6;
    localparam int IQ_DEPTH    = 16;
    localparam int IDX_W       = 4;
    localparam int ALLOC_PORTS = 4;

    typedef struct packed {
        logic [OPCODE-1:0]    op;
        logic [PRF_WIDTH-1:0] prs1;
        logic [PRF_WIDTH-1:0] prs2;
        logic [PRF_WIDTH-1:0] prd;
        logic                 prs1_v;
        logic                 prs2_v;
        logic                 prd_v;
    } ciq_payload_t;

    function automatic logic src_ok(input logic present, input logic rdy);
        return !present | rdy;
    endfunction

endpackage

// File: rtl/ciq_issue_select_age_select.sv
// 16x16 age matrix (older[i][j]=1: i older than j) and one-hot grant of the
// oldest requesting entry.
module ciq_age_select
    import ciq_issue_select_pkg::*;
(
    input  logic                                i_clk,
    input  logic                                i_clr,
    input  logic [IQ_DEPTH-1:0]                 i_occ,
    input  logic [ALLOC_PORTS-1:0]              i_alloc_v,
    input  logic [ALLOC_PORTS-1:0][IDX_W-1:0]   i_alloc_idx,
    input  logic [IQ_DEPTH-1:0]                 i_req,
    output logic [IQ_DEPTH-1:0]                 o_grant
);

    logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0]    r_older;
    logic [IQ_DEPTH-1:0][IQ_DEPTH-1:0]    w_older_nxt;
    logic [ALLOC_PORTS-1:0][IQ_DEPTH-1:0] w_prior;
    logic [IQ_DEPTH-1:0]                  w_blocked;

    // w_prior[k] marks slots written by lower-numbered ports this cycle.
    always_comb begin
        w_prior = '0;
        for (int k = 1; k < ALLOC_PORTS; k++) begin
            w_prior[k] = w_prior[k-1];
            if (i_alloc_v[k-1])
                w_prior[k][i_alloc_idx[k-1]] = 1'b1;
        end
    end

    always_comb begin
        w_older_nxt = r_older;
        for (int k = 0; k < ALLOC_PORTS; k++) begin
            if (i_alloc_v[k]) begin
                w_older_nxt[i_alloc_idx[k]] = '0;
                for (int i = 0; i < IQ_DEPTH; i++)
                    w_older_nxt[i][i_alloc_idx[k]] = i_occ[i] | w_prior[k][i];
            end
        end
    end

    always_comb begin
        w_blocked = '0;
        for (int i = 0; i < IQ_DEPTH; i++)
            for (int j = 0; j < IQ_DEPTH; j++)
                if (i_req[j] & r_older[j][i])
                    w_blocked[i] = 1'b1;
        o_grant = i_req & ~w_blocked;
    end

    always_ff @(posedge i_clk) begin
        if (i_clr)
            r_older <= '0;
        else
            r_older <= w_older_nxt;
    end

endmodule

// File: rtl/ciq_issue_select.sv
// Issue side of the 16-entry centralized issue queue: dispatch writes, tag wakeup,
// oldest-ready select and a single-register valid/ready output stage.
module ciq_issue_select
    import ciq_issue_select_pkg::*;
#(
    parameter int WB_PORTS = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic [ALLOC_PORTS-1:0]                alloc_v,
    input  logic [ALLOC_PORTS-1:0][IDX_W-1:0]     alloc_idx,
    input  logic [ALLOC_PORTS-1:0][OPCODE-1:0]    alloc_op,
    input  logic [ALLOC_PORTS-1:0][PRF_WIDTH-1:0] alloc_prs1,
    input  logic [ALLOC_PORTS-1:0][PRF_WIDTH-1:0] alloc_prs2,
    input  logic [ALLOC_PORTS-1:0][PRF_WIDTH-1:0] alloc_prd,
    input  logic [ALLOC_PORTS-1:0]                alloc_prs1_v,
    input  logic [ALLOC_PORTS-1:0]                alloc_prs2_v,
    input  logic [ALLOC_PORTS-1:0]                alloc_prd_v,
    input  logic [ALLOC_PORTS-1:0]                alloc_prs1_rdy,
    input  logic [ALLOC_PORTS-1:0]                alloc_prs2_rdy,
    input  logic [WB_PORTS-1:0]                   wb_v,
    input  logic [WB_PORTS-1:0][PRF_WIDTH-1:0]    wb_tag,
    output logic [IQ_DEPTH-1:0]                   ciq_free,
    output logic                                  issue_valid,
    input  logic                                  issue_ready,
    output logic [OPCODE-1:0]                     issue_op,
    output logic [PRF_WIDTH-1:0]                  issue_prs1,
    output logic [PRF_WIDTH-1:0]                  issue_prs2,
    output logic [PRF_WIDTH-1:0]                  issue_prd,
    output logic                                  issue_prd_v,
    output logic [IDX_W-1:0]                      issue_idx
);

    ciq_payload_t             r_ent [IQ_DEPTH];
    logic [IQ_DEPTH-1:0]      r_free, r_rdy1, r_rdy2;
    logic                     r_issue_valid, r_issue_prd_v;
    logic [OPCODE-1:0]        r_issue_op;
    logic [PRF_WIDTH-1:0]     r_issue_prs1, r_issue_prs2, r_issue_prd;
    logic [IDX_W-1:0]         r_issue_idx;

    logic                     w_clr, w_load, w_any, w_issue, w_sw_v;
    logic [IQ_DEPTH-1:0]      w_req, w_grant, w_occ;
    logic [IDX_W-1:0]         w_win_idx;
    logic [OPCODE-1:0]        w_win_op;
    logic [PRF_WIDTH-1:0]     w_win_prs1, w_win_prs2, w_win_prd;
    logic                     w_win_prd_v;

    assign w_clr = rst | flush;
    assign w_occ = ~r_free;

    always_comb begin
        for (int i = 0; i < IQ_DEPTH; i++)
            w_req[i] = !r_free[i] & src_ok(r_ent[i].prs1_v, r_rdy1[i])
                                  & src_ok(r_ent[i].prs2_v, r_rdy2[i]);
    end

    ciq_age_select u_age (
        .i_clk       (clk),
        .i_clr       (w_clr),
        .i_occ       (w_occ),
        .i_alloc_v   (alloc_v),
        .i_alloc_idx (alloc_idx),
        .i_req       (w_req),
        .o_grant     (w_grant)
    );

    always_comb begin
        w_win_idx   = '0;
        w_win_op    = '0;
        w_win_prs1  = '0;
        w_win_prs2  = '0;
        w_win_prd   = '0;
        w_win_prd_v = 1'b0;
        for (int i = 0; i < IQ_DEPTH; i++) begin
            if (w_grant[i]) begin
                w_win_idx   = IDX_W'(i);
                w_win_op    = r_ent[i].op;
                w_win_prs1  = r_ent[i].prs1;
                w_win_prs2  = r_ent[i].prs2;
                w_win_prd   = r_ent[i].prd;
                w_win_prd_v = r_ent[i].prd_v;
            end
        end
    end

    assign w_any   = |w_grant;
    assign w_load  = !r_issue_valid | issue_ready;
    assign w_issue = w_load & w_any;
    // The instruction entering the output stage wakes its dependents at this
    // same edge, so they are selectable in the very next cycle.
    assign w_sw_v  = w_issue & w_win_prd_v;

    function automatic logic tag_hit(input logic [PRF_WIDTH-1:0] tag);
        logic hit;
        hit = w_sw_v && (w_win_prd == tag);
        for (int j = 0; j < WB_PORTS; j++)
            if (wb_v[j] && (wb_tag[j] == tag))
                hit = 1'b1;
        return hit;
    endfunction

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_free <= '1;
            r_rdy1 <= '0;
            r_rdy2 <= '0;
        end else begin
            for (int i = 0; i < IQ_DEPTH; i++) begin
                if (!r_free[i] && r_ent[i].prs1_v && tag_hit(r_ent[i].prs1))
                    r_rdy1[i] <= 1'b1;
                if (!r_free[i] && r_ent[i].prs2_v && tag_hit(r_ent[i].prs2))
                    r_rdy2[i] <= 1'b1;
            end
            if (w_issue)
                r_free[w_win_idx] <= 1'b1;
            for (int k = 0; k < ALLOC_PORTS; k++) begin
                if (alloc_v[k]) begin
                    r_free[alloc_idx[k]] <= 1'b0;
                    r_rdy1[alloc_idx[k]] <= alloc_prs1_rdy[k] | tag_hit(alloc_prs1[k]);
                    r_rdy2[alloc_idx[k]] <= alloc_prs2_rdy[k] | tag_hit(alloc_prs2[k]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < ALLOC_PORTS; k++)
            if (alloc_v[k] && !w_clr)
                r_ent[alloc_idx[k]] <= '{op: alloc_op[k], prs1: alloc_prs1[k],
                                         prs2: alloc_prs2[k], prd: alloc_prd[k],
                                         prs1_v: alloc_prs1_v[k], prs2_v: alloc_prs2_v[k],
                                         prd_v: alloc_prd_v[k]};
    end

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_issue_valid <= 1'b0;
            r_issue_op    <= '0;
            r_issue_prs1  <= '0;
            r_issue_prs2  <= '0;
            r_issue_prd   <= '0;
            r_issue_prd_v <= 1'b0;
            r_issue_idx   <= '0;
        end else if (w_load) begin
            r_issue_valid <= w_any;
            if (w_any) begin
                r_issue_op    <= w_win_op;
                r_issue_prs1  <= w_win_prs1;
                r_issue_prs2  <= w_win_prs2;
                r_issue_prd   <= w_win_prd;
                r_issue_prd_v <= w_win_prd_v;
                r_issue_idx   <= w_win_idx;
            end
        end
    end

    // Dispatch must only target free slots, each at most once per cycle.
    always_ff @(posedge clk) begin
        if (!w_clr) begin
            for (int k = 0; k < ALLOC_PORTS; k++) begin
                if (alloc_v[k]) begin
                    assert (r_free[alloc_idx[k]])
                        else $error("alloc into occupied slot %0d", alloc_idx[k]);
                    for (int m = 0; m < k; m++)
                        assert (!(alloc_v[m] && alloc_idx[m] == alloc_idx[k]))
                            else $error("duplicate alloc slot %0d", alloc_idx[k]);
                end
            end
        end
    end

    assign ciq_free    = r_free;
    assign issue_valid = r_issue_valid;
    assign issue_op    = r_issue_op;
    assign issue_prs1  = r_issue_prs1;
    assign issue_prs2  = r_issue_prs2;
    assign issue_prd   = r_issue_prd;
    assign issue_prd_v = r_issue_prd_v;
    assign issue_idx   = r_issue_idx;

endmodule
